// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the latched request record.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] LSU_B  = 3'b000;
    localparam logic [F3_W-1:0] LSU_H  = 3'b001;
    localparam logic [F3_W-1:0] LSU_W  = 3'b010;
    localparam logic [F3_W-1:0] LSU_BU = 3'b100;
    localparam logic [F3_W-1:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic            is_store;
        logic [F3_W-1:0] funct3;
        logic [1:0]      offset;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend, store byte/half merge, and
// detection of misaligned or illegal accesses.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic            is_store,
    input  logic [F3_W-1:0] funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] mem_word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] merge_data_c,
    output logic            err_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = mem_word[7:0];
            2'd1:    byte_lane = mem_word[15:8];
            2'd2:    byte_lane = mem_word[23:16];
            default: byte_lane = mem_word[31:24];
        endcase
        half_lane = offset[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data_c = '0;
        case (funct3)
            LSU_B:   load_data_c = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LSU_BU:  load_data_c = {{(XLEN-8){1'b0}}, byte_lane};
            LSU_H:   load_data_c = {{(XLEN-16){half_lane[15]}}, half_lane};
            LSU_HU:  load_data_c = {{(XLEN-16){1'b0}}, half_lane};
            LSU_W:   load_data_c = mem_word;
            default: load_data_c = '0;
        endcase
    end

    // Merge keeps the untouched bytes of the word read back from memory.
    always_comb begin
        merge_data_c = mem_word;
        case (funct3)
            LSU_B: begin
                case (offset)
                    2'd0:    merge_data_c[7:0]   = wdata[7:0];
                    2'd1:    merge_data_c[15:8]  = wdata[7:0];
                    2'd2:    merge_data_c[23:16] = wdata[7:0];
                    default: merge_data_c[31:24] = wdata[7:0];
                endcase
            end
            LSU_H: begin
                if (offset[1]) merge_data_c[31:16] = wdata[15:0];
                else           merge_data_c[15:0]  = wdata[15:0];
            end
            LSU_W:   merge_data_c = wdata;
            default: merge_data_c = mem_word;
        endcase
    end

    always_comb begin
        if (is_store) begin
            illegal = !(funct3 == LSU_B || funct3 == LSU_H || funct3 == LSU_W);
        end else begin
            illegal = !(funct3 == LSU_B || funct3 == LSU_H || funct3 == LSU_W ||
                        funct3 == LSU_BU || funct3 == LSU_HU);
        end
        misaligned = ((funct3 == LSU_H || funct3 == LSU_HU) && offset[0]) ||
                     ((funct3 == LSU_W) && (offset != 2'b00));
        err_c = illegal || misaligned;
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed memory with combinational
// read; sub-word stores go through a read-modify-write sequence.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [XLEN-1:0]   mem_wd,
    input  logic [XLEN-1:0]   mem_rd
);

    lsu_state_t        state_q, state_d;
    lsu_req_t          req_q, req_d;
    lsu_req_t          align_req;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [XLEN-1:0]   mem_wd_q, mem_wd_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              req_ready_q, req_ready_d;
    logic [XLEN-1:0]   load_data_c;
    logic [XLEN-1:0]   merge_data_c;
    logic              align_err_c;

    // In IDLE the lane logic looks at the live request to classify it;
    // afterwards it works on the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            align_req.is_store = req_op[3];
            align_req.funct3   = req_op[2:0];
            align_req.offset   = req_addr[1:0];
            align_req.wdata    = req_wdata;
        end else begin
            align_req = req_q;
        end
    end

    lsu_lane_align u_lane_align (
        .is_store     (align_req.is_store),
        .funct3       (align_req.funct3),
        .offset       (align_req.offset),
        .mem_word     (mem_rd),
        .wdata        (align_req.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c),
        .err_c        (align_err_c)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d        = align_req;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    if (align_err_c) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        mem_a_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!align_req.is_store) begin
                            state_d = LOAD;
                        end else if (align_req.funct3 == LSU_W) begin
                            mem_wd_d = req_wdata;
                            state_d  = STORE;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                resp_rdata_d = load_data_c;
                state_d      = RESP;
            end
            RMW_RD: begin
                mem_wd_d = merge_data_c;
                state_d  = STORE;
            end
            STORE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are pure functions of the next state, so each one
        // is a flop that tracks the state register exactly.
        mem_we_d     = (state_d == STORE);
        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_we     = mem_we_q;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// traffic against a byte-level reference model of the memory.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    logic [31:0] tb_mem  [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_cnt   = 0;
    logic [31:0] exp_we_addr = '0;
    logic [31:0] exp_we_data = '0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // 16-word memory that aliases on the upper address bits.
    assign mem_rd = tb_mem[mem_a[5:2]];
    always @(posedge clk) begin
        if (pl_en)       tb_mem[pl_idx]     <= pl_val;
        else if (mem_we) tb_mem[mem_a[5:2]] <= mem_wd;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            check_eq("we_addr", mem_a, exp_we_addr);
            check_eq("we_data", mem_wd, exp_we_data);
        end
    end

    // Reference: RV32I semantics on a word array using byte arithmetic.
    task automatic ref_exec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int lat, output int wes);
        logic        is_store = op[3];
        logic [2:0]  f3       = op[2:0];
        int unsigned idx      = (addr / 4) % 16;
        int unsigned sh       = (addr % 4) * 8;
        int unsigned size;
        logic [63:0] mask;
        logic [63:0] val;
        logic        legal;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mask  = (64'd1 << (8 * size)) - 64'd1;
        legal = is_store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || ((addr % size) != 0);
        rd    = '0;
        wes   = 0;
        lat   = 1;
        if (!err && !is_store) begin
            lat = 2;
            val = ({32'd0, ref_mem[idx]} >> sh) & mask;
            if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | ~mask;
            rd = val[31:0];
        end else if (!err) begin
            wes = 1;
            lat = (size == 4) ? 2 : 3;
            val = ({32'd0, ref_mem[idx]} & ~(mask << sh)) | (({32'd0, wd} & mask) << sh);
            ref_mem[idx] = val[31:0];
            exp_we_data  = val[31:0];
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 4'(idx); pl_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          e_we;
        int          we0;
        int          lat;
        ref_exec(op, addr, wd, e_rd, e_err, e_lat, e_we);
        exp_we_addr = {addr[31:2], 2'b00};
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1);
        we0 = we_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end while (!resp_valid && lat < 10);
        check_eq("latency", lat, e_lat);
        for (int i = 0; i < hold; i++) begin
            check_eq("stall_valid", resp_valid, 1);
            check_eq("stall_rdata", resp_rdata, e_rd);
            check_eq("stall_ready", req_ready, 0);
            if (i == 2) begin
                req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h0; req_wdata = '0;
            end
            if (i == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_rdata", resp_rdata, e_rd);
        check_eq("resp_err", resp_err, e_err);
        check_eq("we_pulses", we_cnt - we0, e_we);
        @(negedge clk);
        check_eq("back_idle_valid", resp_valid, 0);
        check_eq("back_idle_ready", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ops [8];
        logic [3:0]  op;
        logic [31:0] addr;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        #2;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_a", mem_a, 0);
        check_eq("rst_mem_wd", mem_wd, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(0, 32'h11111111);
        preload(1, 32'h1FD961AB);
        preload(2, 32'h22222222);

        do_txn(4'b0010, 32'h4, '0, 0);            // LW
        do_txn(4'b0000, 32'h4, '0, 0);            // LB
        do_txn(4'b0100, 32'h7, '0, 0);            // LBU
        do_txn(4'b0001, 32'h6, '0, 0);            // LH
        do_txn(4'b0101, 32'h4, '0, 0);            // LHU
        do_txn(4'b1000, 32'h2, 32'hABCD12CC, 0);  // SB
        do_txn(4'b0010, 32'h0, '0, 0);
        check_eq("sb_merged_word", tb_mem[0], 32'h11CC1111);
        do_txn(4'b0010, 32'h5, '0, 0);            // misaligned LW
        do_txn(4'b1001, 32'h3, 32'h5555, 0);      // misaligned SH
        check_eq("err_mem_unchanged", tb_mem[0], 32'h11CC1111);
        do_txn(4'b0011, 32'h8, '0, 0);            // illegal funct3
        do_txn(4'b1100, 32'h8, '0, 0);            // illegal store funct3
        do_txn(4'b0010, 32'h4, '0, 5);            // stalled response

        // SW cut short by reset while in STORE
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1010; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        exp_we_addr = 32'h8; exp_we_data = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("store_we_before_rst", mem_we, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_we", mem_we, 0);
        check_eq("rst_async_ready", req_ready, 1);
        check_eq("rst_async_valid", resp_valid, 0);
        check_eq("rst_async_wd", mem_wd, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", req_ready, 1);
        check_eq("post_rst_valid", resp_valid, 0);
        check_eq("post_rst_word2", tb_mem[2], ref_mem[2]);

        for (int n = 0; n < 200; n++) begin
            op   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            do_txn(op, addr, $urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        for (int i = 0; i < 16; i++) check_eq("final_mem", tb_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
